// File: rtl/router_fifo.sv
// Per-port 16x9 output buffer for the 1x3 router, with a read-side packet-length counter.
// Define ROUTER_FIFO_TRISTATE_EN to make data_out float (8'bz) while idle.
module router_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int unsigned CW = WIDTH - 1;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
`ifdef ROUTER_FIFO_TRISTATE_EN
  localparam logic [WIDTH-1:0] IDLE = 'z;
`else
  localparam logic [WIDTH-1:0] IDLE = '0;
`endif

  logic [WIDTH:0]  mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [CW-1:0]   pkt_cnt;
  logic            wr_acc;
  logic            rd_acc;
  logic [WIDTH:0]  rd_word;

  // Flags come straight from the registered pointers; MSB is the wrap bit.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_acc  = write_enb && !full;
  assign rd_acc  = read_enb && !empty;
  assign rd_word = mem[rd_ptr[AW-1:0]];

  // Storage: cleared by hard reset only, a flush leaves contents in place.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_acc && !soft_reset) begin
      mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn || soft_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      data_out <= IDLE;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        data_out <= rd_word[WIDTH-1:0];
        // Header carries payload length in bits [7:2]; +1 accounts for parity.
        if (rd_word[WIDTH])
          pkt_cnt <= CW'(rd_word[WIDTH-1:2]) + CNT_ONE;
        else if (pkt_cnt != '0)
          pkt_cnt <= pkt_cnt - CNT_ONE;
      end else if (pkt_cnt == '0) begin
        data_out <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo: reset, packet read-out, full/empty,
// simultaneous access, pointer wrap and mid-packet flush.
module tb_router_fifo;

`ifdef ROUTER_FIFO_TRISTATE_EN
  localparam logic [7:0] IDLE = 8'hzz;
`else
  localparam logic [7:0] IDLE = 8'h00;
`endif

  logic       clock = 1'b0;
  logic       resetn, soft_reset, write_enb, read_enb, lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full, empty;

  int n_checks = 0;
  int n_fail   = 0;

  router_fifo dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic hdr);
    write_enb = 1'b1;
    lfd_state = hdr;
    data_in   = d;
    tick();
    write_enb = 1'b0;
    lfd_state = 1'b0;
  endtask

  // One read cycle, then check the presented byte.
  task automatic pop(input string tag, input logic [7:0] exp);
    read_enb = 1'b1;
    tick();
    read_enb = 1'b0;
    check(tag, data_out, exp);
  endtask

  initial begin
    logic [7:0] pkt [5];
    pkt = '{8'h0C, 8'hA1, 8'hA2, 8'hA3, 8'h5F};
    resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    lfd_state = 1'b0; data_in = 8'h00;
    tick(); tick();
    check("rst_empty", 8'(empty), 8'd1);
    check("rst_full", 8'(full), 8'd0);
    check("rst_dout", data_out, IDLE);
    resetn = 1'b1;

    // Single packet: header 0C -> length 3 + parity = 4.
    push(8'h0C, 1'b1);
    for (int i = 1; i < 5; i++) push(pkt[i], 1'b0);
    check("pkt_not_empty", 8'(empty), 8'd0);
    read_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("pkt_data", data_out, pkt[i]);
      check("pkt_cnt", 8'(dut.pkt_cnt), 8'(4 - i));
    end
    check("pkt_empty", 8'(empty), 8'd1);
    tick();
    read_enb = 1'b0;
    check("pkt_idle", data_out, IDLE);

    // Fill to full, extra write dropped.
    for (int i = 0; i < 16; i++) begin
      check("fill_not_full", 8'(full), 8'd0);
      push(8'(i), 1'b0);
    end
    check("fill_full", 8'(full), 8'd1);
    push(8'hFF, 1'b0);
    check("fill_still_full", 8'(full), 8'd1);

    // Read and write together while full: read wins, write dropped.
    write_enb = 1'b1; read_enb = 1'b1; data_in = 8'hFF;
    tick();
    write_enb = 1'b0; read_enb = 1'b0;
    check("sim_data", data_out, 8'h00);
    check("sim_full", 8'(full), 8'd0);
    for (int i = 1; i < 16; i++) pop("drain_data", 8'(i));
    check("drain_empty", 8'(empty), 8'd1);

    // Pointer wrap: 3 rounds of 10 in / 10 out.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) push(8'(8'h40 + r * 16 + i), 1'b0);
      check("wrap_not_full", 8'(full), 8'd0);
      for (int i = 0; i < 10; i++) pop("wrap_data", 8'(8'h40 + r * 16 + i));
      check("wrap_empty", 8'(empty), 8'd1);
    end

    // Flush mid-packet: header 14 -> count 6.
    push(8'h14, 1'b1);
    for (int i = 1; i < 6; i++) push(8'(i), 1'b0);
    pop("sr_hdr", 8'h14);
    check("sr_cnt_hdr", 8'(dut.pkt_cnt), 8'd6);
    pop("sr_p1", 8'h01);
    check("sr_cnt_p1", 8'(dut.pkt_cnt), 8'd5);
    soft_reset = 1'b1; write_enb = 1'b1; data_in = 8'hEE;
    tick();
    soft_reset = 1'b0; write_enb = 1'b0;
    check("sr_empty", 8'(empty), 8'd1);
    check("sr_full", 8'(full), 8'd0);
    check("sr_cnt", 8'(dut.pkt_cnt), 8'd0);
    check("sr_dout", data_out, IDLE);
    // Header 04 -> length 1 + parity = 2.
    push(8'h04, 1'b1);
    push(8'h33, 1'b0);
    pop("post_hdr", 8'h04);
    check("post_cnt", 8'(dut.pkt_cnt), 8'd2);
    pop("post_p", 8'h33);
    check("post_cnt2", 8'(dut.pkt_cnt), 8'd1);
    check("post_empty", 8'(empty), 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- One of three identical per-port output buffers in the 1x3 router.
- Sits directly downstream of the synchronizer, which drives write_enb, soft_reset and read_enb per port and consumes full/empty.
- Stores 16 words of 9 bits each (8 data bits plus a header flag).
- Tracks packet length on the read side so the output idles between packets.

Parameters:
- DEPTH, 16, number of storage words (power of two).
- WIDTH, 8, data bits per word; the stored word is WIDTH+1 bits (MSB = header flag).
- AW, 4, address width, log2(DEPTH); pointers are AW+1 bits.

Ports:
- clock  input  1  rising-edge clock
- resetn  input  1  synchronous, active-low reset
- soft_reset  input  1  synchronous, active-high flush from the synchronizer timeout
- write_enb  input  1  write request (this port's bit of the synchronizer's write_enb)
- read_enb  input  1  read request from the destination
- lfd_state  input  1  high while the header byte is on data_in; stored as the header flag
- data_in  input  8  write data
- data_out  output  8  registered read data
- full  output  1  FIFO holds DEPTH words
- empty  output  1  FIFO holds 0 words

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. Priority order is resetn, then soft_reset, then normal operation.
- State on resetn=0 or soft_reset=1, at the clock edge:
  - wr_ptr=0, rd_ptr=0, pkt_cnt=0, data_out=idle value.
  - Memory is cleared to 0 on resetn; soft_reset leaves memory untouched.
  - Resulting outputs: full=0, empty=1.
- Pointers: 5-bit wr_ptr/rd_ptr; the low AW bits address memory and the MSB is a wrap bit.
- Flags (combinational from registered pointers):
  - empty = (wr_ptr == rd_ptr)
  - full = (MSBs differ and low AW bits equal)
- Write:
  - Accepted when write_enb=1 and full=0.
  - mem[wr_ptr] <= {lfd_state, data_in}; wr_ptr increments and wraps 31 to 0.
  - write_enb while full is ignored; no pointer change, no overwrite.
- Read:
  - Accepted when read_enb=1 and empty=0.
  - data_out <= mem[rd_ptr][7:0] on that edge, so data appears 1 cycle after read_enb is sampled; rd_ptr increments.
  - read_enb while empty is ignored.
- Simultaneous read and write:
  - Both are evaluated against pre-edge flags.
  - When full: the read succeeds and the write is dropped.
  - When empty: the write succeeds and the read is ignored.
  - Otherwise both succeed and occupancy is unchanged.
- Packet counter pkt_cnt (7 bits), updated on accepted reads only:
  - Word with header flag=1: pkt_cnt <= mem[rd_ptr][7:2] + 1 (payload length plus parity byte, range 1..64).
  - Word with header flag=0 and pkt_cnt != 0: pkt_cnt <= pkt_cnt - 1.
  - Word with header flag=0 and pkt_cnt == 0: pkt_cnt stays 0 (stray byte); data is still presented.
- Idle output:
  - Condition: pkt_cnt == 0 and no accepted read this cycle.
  - Action: data_out <= idle value on that edge.
  - Otherwise data_out holds its last value.
- Soft reset mid-packet: the flush discards all stored words and the counter; writes in the same cycle are dropped.
- Reset mid-operation behaves identically to soft reset, except that memory is also cleared.

Optional Feature:
- Macro: ROUTER_FIFO_TRISTATE_EN.
- Defined: the idle value of data_out is high-impedance (8'bz), for a shared-bus top level.
- Undefined: the idle value is 8'h00; the design is fully synthesizable with no tristates.
- Nothing else differs.

Test Plan:
- Reset and flags: resetn=0 for 2 cycles -> empty=1, full=0, data_out=8'h00 (tristate build: 8'hzz).
- Single packet:
  - Stimulus: write header 8'h0C with lfd_state=1, then payload 8'hA1, 8'hA2, 8'hA3 and parity 8'h5F with lfd_state=0; then hold read_enb=1.
  - Required: data_out sequence 0C, A1, A2, A3, 5F, each 1 cycle after its read.
  - pkt_cnt goes 4, 3, 2, 1, 0.
  - data_out returns to the idle value on the edge after the last read.
- Fill to full:
  - Stimulus: write 16 words 8'h00..8'h0F, then a 17th write 8'hFF.
  - Required: full=1 after the 16th write; 8'hFF is not stored; the subsequent 16 reads return 00..0F and then empty=1.
- Simultaneous access when full: read_enb=1 and write_enb=1 with full=1 -> one word is read, the write is dropped, full deasserts.
- Wrap-around: 10 writes and 10 reads, repeated 3 times -> data is preserved across the pointer wrap and empty=1 at the end of each round.
- Soft reset mid-packet:
  - Stimulus: header 8'h14, read 2 bytes, then soft_reset=1 for 1 cycle.
  - Required: empty=1, pkt_cnt=0, data_out at the idle value; the next header then reads correctly.
